lcd_stream_ctrl: RTL
====================

LCD_STREAM_CTRL -- requirements
Module: lcd_stream_ctrl

Parameters
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, giving the number of queued words (power of two, >=2).
REQ-002 The block SHALL have parameter POWERUP_CYCLES, default 40000, giving the idle cycles after reset before the first transfer.
REQ-003 The block SHALL have parameter SETUP_CYCLES, default 2, giving the cycles that data/rs are stable before e rises (>=1).
REQ-004 The block SHALL have parameter E_CYCLES, default 20, giving the e high width in cycles (>=1).
REQ-005 The block SHALL have parameter CMD_WAIT_CYCLES, default 2000, giving the post-pulse wait for ordinary words.
REQ-006 The block SHALL have parameter CLEAR_WAIT_CYCLES, default 80000, giving the post-pulse wait after command 0x01, 0x02 or 0x03.
REQ-007 The block SHALL have parameters TWO_LINE=1, FONT_5X10=1, CURSOR_ON=1 and BLINK_ON=1, giving the init configuration bits.

Interface
REQ-008 The block SHALL have input Clock, 1 bit: the single system clock; all logic is on the rising edge.
REQ-009 The block SHALL have input Reset, 1 bit: synchronous, active-high reset.
REQ-010 The block SHALL have input in_valid, 1 bit: a word is offered on in_data.
REQ-011 The block SHALL have input in_data, 9 bits: bit 8 is rs (1 = data, 0 = command) and bits 7:0 are the byte.
REQ-012 The block SHALL have output in_ready, 1 bit: the FIFO is not full.
REQ-013 The block SHALL have output data, 8 bits: the LCD data bus.
REQ-014 The block SHALL have output rs, 1 bit: the LCD register select.
REQ-015 The block SHALL have output rw, 1 bit: tied 0 (write only).
REQ-016 The block SHALL have output e, 1 bit: the LCD enable strobe.
REQ-017 The block SHALL have output init_done, 1 bit: high once the init sequence has completed.
REQ-018 The block SHALL have output busy, 1 bit: a transfer or wait is in progress.
REQ-019 The block SHALL have output fifo_count, $clog2(FIFO_DEPTH)+1 bits: the current FIFO occupancy.

Function
REQ-020 The block SHALL implement the states POWERUP, LOAD, SETUP, PULSE, WAIT and IDLE.
REQ-021 In POWERUP the block SHALL hold data=0, rs=0 and e=0 for POWERUP_CYCLES, then go to LOAD.
REQ-022 The init sequence SHALL be the four commands, rs=0, in this order: function set 0x30|TWO_LINE<<3|FONT_5X10<<2 (default 0x3C); 0x06; 0x01; and 0x0C|CURSOR_ON<<1|BLINK_ON (default 0x0F).
REQ-023 In LOAD the block SHALL drive data/rs from the next init word, or after init from the FIFO head (popping it), then go to SETUP.
REQ-024 In SETUP the block SHALL keep e=0 for SETUP_CYCLES, then go to PULSE.
REQ-025 In PULSE the block SHALL keep e=1 for E_CYCLES, then go to WAIT.
REQ-026 data and rs SHALL remain stable from LOAD through the end of WAIT.
REQ-027 In WAIT the block SHALL keep e=0 for CLEAR_WAIT_CYCLES if rs=0 and the byte is 0x01, 0x02 or 0x03, and otherwise for CMD_WAIT_CYCLES.
REQ-028 On leaving WAIT the block SHALL go to LOAD if further init words remain or the FIFO is non-empty, and otherwise to IDLE.
REQ-029 IDLE SHALL hold the last data/rs with e=0 and SHALL move to LOAD in the cycle after the FIFO becomes non-empty.
REQ-030 init_done SHALL rise at the end of the fourth init WAIT and stay high until reset.
REQ-031 busy SHALL be high in every state except IDLE.
REQ-032 The FIFO SHALL accept a word on a cycle where in_valid=1 and in_ready=1, in any state including POWERUP and init.
REQ-033 in_ready SHALL be 0 exactly when fifo_count==FIFO_DEPTH, and an offered word SHALL be held by the source, never dropped.
REQ-034 A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-035 A push when the FIFO is empty and the block is in IDLE SHALL appear on the bus no earlier than the cycle after the push.
REQ-036 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, and words SHALL exit in arrival order.
REQ-037 All timing counters SHALL be wide enough for the largest parameter, with no wrap-around during a count.

Reset
REQ-038 While Reset=1, data, rs, rw, e, init_done and busy SHALL be 0 and fifo_count SHALL be 0 on the next edge.
REQ-039 Reset SHALL empty the FIFO and restart from POWERUP.
REQ-040 Reset asserted mid-PULSE SHALL drive e=0 on the very next edge, and no partial transfer SHALL resume after release.

Verification
Parameters for these scenarios: POWERUP=10, SETUP=2, E=3, CMD_WAIT=5, CLEAR_WAIT=20, DEPTH=4.
REQ-041 Bench SHALL cover reset: hold Reset for 3 cycles -> all outputs 0, in_ready=1 and fifo_count=0.
REQ-042 Bench SHALL cover init: release Reset -> the e high pulses, each 3 cycles wide, carry data 0x3C, 0x06, 0x01 and 0x0F with rs=0; the gap from e falling to the next e rising is 7 cycles, except 22 cycles after 0x01; init_done then rises.
REQ-043 Bench SHALL cover streaming: push 0x105 after init_done -> e pulses with data=0x05, rs=1 and rw=0; busy returns to 0 after the wait.
REQ-044 Bench SHALL cover full FIFO: push 6 words during POWERUP -> in_ready goes low after the 4th word; the 5th and 6th are accepted as pops occur; all 6 words are output in order.
REQ-045 Bench SHALL cover the home command: push 0x002 then 0x141 -> the gap between the two pulses equals CLEAR_WAIT+SETUP (22 cycles).
REQ-046 Bench SHALL cover reset mid-pulse: assert Reset while e=1 -> e=0 on the next edge; after release the sequence restarts with 0x3C after POWERUP.

Source files
------------

// File: rtl/lcd_stream_ctrl.sv
// rtl/lcd_stream_ctrl.sv - HD44780-style LCD write controller with init sequencer and word FIFO
module lcd_stream_ctrl #(
    parameter int FIFO_DEPTH        = 8,
    parameter int POWERUP_CYCLES    = 40000,
    parameter int SETUP_CYCLES      = 2,
    parameter int E_CYCLES          = 20,
    parameter int CMD_WAIT_CYCLES   = 2000,
    parameter int CLEAR_WAIT_CYCLES = 80000,
    parameter int TWO_LINE          = 1,
    parameter int FONT_5X10         = 1,
    parameter int CURSOR_ON         = 1,
    parameter int BLINK_ON          = 1
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          in_valid,
    input  logic [8:0]                    in_data,
    output logic                          in_ready,
    output logic [7:0]                    data,
    output logic                          rs,
    output logic                          rw,
    output logic                          e,
    output logic                          init_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam int M1      = (POWERUP_CYCLES > CLEAR_WAIT_CYCLES) ? POWERUP_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int M2      = (M1 > CMD_WAIT_CYCLES) ? M1 : CMD_WAIT_CYCLES;
    localparam int M3      = (M2 > E_CYCLES) ? M2 : E_CYCLES;
    localparam int MAX_CYC = (M3 > SETUP_CYCLES) ? M3 : SETUP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] S_POWERUP = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SETUP   = 3'd2;
    localparam logic [2:0] S_PULSE   = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_IDLE    = 3'd5;

    localparam logic [7:0] INIT_FUNC  = {4'h3, (TWO_LINE != 0), (FONT_5X10 != 0), 2'b00};
    localparam logic [7:0] INIT_ENTRY = 8'h06;
    localparam logic [7:0] INIT_CLEAR = 8'h01;
    localparam logic [7:0] INIT_DISP  = {4'h0, 2'b11, (CURSOR_ON != 0), (BLINK_ON != 0)};
    localparam logic [2:0] INIT_WORDS = 3'd4;

    logic [8:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 push;
    logic                 pop;

    logic [2:0]           state;
    logic [2:0]           state_nx;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nx;
    logic [2:0]           init_idx;
    logic                 go_load;
    logic                 load_fifo;
    logic                 is_clear;
    logic                 rst_q;
    logic [7:0]           init_word;
    logic [8:0]           load_word;

    assign in_ready   = (count != (AW + 1)'(FIFO_DEPTH));
    assign fifo_count = count;
    assign rw         = 1'b0;
    assign busy       = (state != S_IDLE) && !rst_q;

    assign push      = in_valid && in_ready;
    assign load_fifo = (init_idx == INIT_WORDS);
    assign pop       = go_load && load_fifo;
    // Clear/home/return commands need the long settle time
    assign is_clear  = !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);

    always_comb begin
        init_word = INIT_FUNC;
        case (init_idx[1:0])
            2'd0:    init_word = INIT_FUNC;
            2'd1:    init_word = INIT_ENTRY;
            2'd2:    init_word = INIT_CLEAR;
            default: init_word = INIT_DISP;
        endcase
    end

    assign load_word = load_fifo ? mem[rd_ptr] : {1'b0, init_word};

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // LOAD is counted as the first setup cycle, so e=0 spans exactly SETUP_CYCLES before rising
    always_comb begin
        state_nx = state;
        cnt_nx   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        go_load  = 1'b0;
        case (state)
            S_POWERUP: begin
                if (cnt == '0) begin
                    state_nx = S_LOAD;
                    go_load  = 1'b1;
                end
            end
            S_LOAD: begin
                if (SETUP_CYCLES > 1) begin
                    state_nx = S_SETUP;
                    cnt_nx   = CNT_W'(SETUP_CYCLES - 2);
                end else begin
                    state_nx = S_PULSE;
                    cnt_nx   = CNT_W'(E_CYCLES - 1);
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_nx = S_PULSE;
                    cnt_nx   = CNT_W'(E_CYCLES - 1);
                end
            end
            S_PULSE: begin
                if (cnt == '0) begin
                    state_nx = S_WAIT;
                    cnt_nx   = is_clear ? CNT_W'(CLEAR_WAIT_CYCLES - 1)
                                        : CNT_W'(CMD_WAIT_CYCLES - 1);
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    if (!load_fifo || (count != '0)) begin
                        state_nx = S_LOAD;
                        go_load  = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                if (count != '0) begin
                    state_nx = S_LOAD;
                    go_load  = 1'b1;
                end
            end
            default: begin
                state_nx = S_POWERUP;
                cnt_nx   = CNT_W'(POWERUP_CYCLES - 1);
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= S_POWERUP;
            cnt       <= CNT_W'(POWERUP_CYCLES - 1);
            init_idx  <= '0;
            init_done <= 1'b0;
            data      <= '0;
            rs        <= 1'b0;
            e         <= 1'b0;
            rst_q     <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            e     <= (state_nx == S_PULSE);
            rst_q <= 1'b0;
            if (go_load) begin
                rs   <= load_word[8];
                data <= load_word[7:0];
                if (!load_fifo) begin
                    init_idx <= init_idx + 1'b1;
                end
            end
            if ((state == S_WAIT) && (cnt == '0) && load_fifo) begin
                init_done <= 1'b1;
            end
        end
    end

endmodule
